fp64_result_pack: RTL and testbench

FP64_RESULT_PACK -- requirements
Module: fp64_result_pack

---
 rtl/fp64_pkg.sv | 32 +++
 rtl/fp64_round.sv | 34 +++
 rtl/fp64_result_pack.sv | 121 ++++++++++++
 tb/tb_fp64_result_pack.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp64_pkg.sv
// ============================================================================
// fp64_pkg
// Shared binary64 field widths, special constants and the S1->S2 stage record.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fp64_pkg;

    localparam int EXP_W   = 11;
    localparam int MAN_W   = 52;
    localparam int BIAS    = 1023;
    localparam int EXP_MAX = 2047;
    localparam int PROD_W  = 2 * (MAN_W + 1);
    // Unbiased exponent needs two extra bits: one for sign, one for 2x range
    localparam int EXPI_W  = EXP_W + 2;

    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    typedef struct packed {
        logic              sign;
        logic [EXPI_W-1:0] exp13;
        logic [MAN_W-1:0]  mant;
        logic              guard;
        logic              sticky;
        logic              zero;
        logic              nan;
    } s1_stage_t;

endpackage

`default_nettype wire

// File: rtl/fp64_round.sv
// ============================================================================
// fp64_round
// Mantissa rounding; round-to-nearest-even when FP64_PACK_ROUND_EN is defined,
// otherwise truncation. Revision: 1.0
// ============================================================================
`default_nettype none

module fp64_round
    import fp64_pkg::*;
(
    input  logic [MAN_W-1:0] mant_in,
    input  logic             guard,
    input  logic             sticky,
    output logic [MAN_W-1:0] mant_out,
    output logic             carry
);

`ifdef FP64_PACK_ROUND_EN
    logic inc;

    assign inc = guard & (sticky | mant_in[0]);
    // Carry-out leaves mant_out at zero, which is the correct 1.0 x 2^(e+1)
    assign {carry, mant_out} = {1'b0, mant_in} + {{MAN_W{1'b0}}, inc};
`else
    logic unused_round_bits;

    assign unused_round_bits = guard ^ sticky;
    assign mant_out          = mant_in;
    assign carry             = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/fp64_result_pack.sv
// ============================================================================
// fp64_result_pack
// Two-stage normalize / round-pack of a binary64 product (FP64_PACK_ROUND_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module fp64_result_pack
    import fp64_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sign,
    input  logic [11:0]   in_esum,
    input  logic [105:0]  in_prod,
    input  logic          in_zero,
    input  logic          in_nan,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [63:0]   out_result,
    output logic          out_of,
    output logic          out_uf
);

    localparam logic signed [EXPI_W-1:0] EXP_LIM = EXPI_W'(EXP_MAX);

    logic              s1_valid;
    s1_stage_t         s1_q;
    s1_stage_t         s1_d;
    logic              s2_accept;
    logic              norm;
    logic [MAN_W-1:0]  mant_r;
    logic              carry;
    logic [EXPI_W-1:0] exp_r;
    logic [63:0]       res_d;
    logic              of_d;
    logic              uf_d;

    assign s2_accept = !out_valid || out_ready;
    assign in_ready  = !s1_valid || s2_accept;

    // S1: product is 1x.xx or 01.xx; pick the 52 bits under the leading one
    always_comb begin
        norm         = in_prod[PROD_W-1];
        s1_d         = '0;
        s1_d.sign    = in_sign;
        s1_d.zero    = in_zero;
        s1_d.nan     = in_nan;
        s1_d.exp13   = {1'b0, in_esum} - EXPI_W'(BIAS) + {{(EXPI_W-1){1'b0}}, norm};
        if (norm) begin
            s1_d.mant   = in_prod[104:53];
            s1_d.guard  = in_prod[52];
            s1_d.sticky = |in_prod[51:0];
        end else begin
            s1_d.mant   = in_prod[103:52];
            s1_d.guard  = in_prod[51];
            s1_d.sticky = |in_prod[50:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    fp64_round u_round (
        .mant_in  (s1_q.mant),
        .guard    (s1_q.guard),
        .sticky   (s1_q.sticky),
        .mant_out (mant_r),
        .carry    (carry)
    );

    assign exp_r = s1_q.exp13 + {{(EXPI_W-1){1'b0}}, carry};

    // S2: special cases take priority over range checks on the rounded exponent
    always_comb begin
        res_d = {s1_q.sign, exp_r[EXP_W-1:0], mant_r};
        of_d  = 1'b0;
        uf_d  = 1'b0;
        if (s1_q.nan) begin
            res_d = QNAN;
        end else if (s1_q.zero) begin
            res_d = {s1_q.sign, 63'b0};
        end else if ($signed(exp_r) >= EXP_LIM) begin
            res_d = {s1_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            of_d  = 1'b1;
        end else if ($signed(exp_r) <= $signed({EXPI_W{1'b0}})) begin
            res_d = {s1_q.sign, 63'b0};
            uf_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_of     <= 1'b0;
            out_uf     <= 1'b0;
        end else if (s2_accept) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= res_d;
                out_of     <= of_d;
                out_uf     <= uf_d;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fp64_result_pack.sv
// ============================================================================
// tb_fp64_result_pack
// Directed bench for fp64_result_pack; honours FP64_PACK_ROUND_EN. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fp64_result_pack;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         in_sign;
    logic [11:0]  in_esum;
    logic [105:0] in_prod;
    logic         in_zero;
    logic         in_nan;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_result;
    logic         out_of;
    logic         out_uf;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [105:0] ONE     = 106'd1 << 104;
    localparam logic [105:0] ALLONES = (106'd1 << 105) - 106'd1;

`ifdef FP64_PACK_ROUND_EN
    localparam logic [65:0] TIE_EXP   = {64'h3FF0_0000_0000_0002, 2'b00};
    localparam logic [65:0] CARRY_EXP = {64'h4000_0000_0000_0000, 2'b00};
    localparam logic [65:0] CTOP_EXP  = {64'h7FF0_0000_0000_0000, 2'b10};
`else
    localparam logic [65:0] TIE_EXP   = {64'h3FF0_0000_0000_0001, 2'b00};
    localparam logic [65:0] CARRY_EXP = {64'h3FFF_FFFF_FFFF_FFFF, 2'b00};
    localparam logic [65:0] CTOP_EXP  = {64'h7FEF_FFFF_FFFF_FFFF, 2'b00};
`endif

    fp64_result_pack dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_esum    (in_esum),
        .in_prod    (in_prod),
        .in_zero    (in_zero),
        .in_nan     (in_nan),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_of     (out_of),
        .out_uf     (out_uf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic v, input logic s, input logic [11:0] e,
                          input logic [105:0] p, input logic z, input logic n);
        in_valid = v; in_sign = s; in_esum = e; in_prod = p; in_zero = z; in_nan = n;
    endtask

    // One transaction into an empty pipe with out_ready high; captures valid
    // after the first and second edges plus the result/flags after the second.
    task automatic xact(input logic s, input logic [11:0] e, input logic [105:0] p,
                        input logic z, input logic n, output logic [67:0] obs);
        logic v1;
        @(negedge clk);
        out_ready = 1'b1;
        set_in(1'b1, s, e, p, z, n);
        @(posedge clk); #1;
        v1 = out_valid;
        in_valid = 1'b0;
        @(posedge clk); #1;
        obs = {v1, out_valid, out_result, out_of, out_uf};
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        out_ready = 1'b0;
        set_in(1'b0, 1'b0, 12'd0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, out_result, out_of, out_uf} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b r=%h of=%b uf=%b want all zero",
                     out_valid, out_result, out_of, out_uf);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_normal;
        logic [67:0] o;
        xact(1'b0, 12'd2046, ONE, 1'b0, 1'b0, o);
        n_cmp++;
        if (o !== {2'b01, 64'h3FF0_0000_0000_0000, 2'b00}) begin
            n_fail++; $display("FAIL one_x_one: got %h want %h", o, {2'b01, 64'h3FF0_0000_0000_0000, 2'b00});
        end
        xact(1'b0, 12'd2046, 106'd9 << 102, 1'b0, 1'b0, o);
        n_cmp++;
        if (o !== {2'b01, 64'h4002_0000_0000_0000, 2'b00}) begin
            n_fail++; $display("FAIL onep5_sq: got %h want %h", o, {2'b01, 64'h4002_0000_0000_0000, 2'b00});
        end
        xact(1'b1, 12'd2046, (106'd3 << 103), 1'b0, 1'b0, o);
        n_cmp++;
        if (o !== {2'b01, 64'hBFF8_0000_0000_0000, 2'b00}) begin
            n_fail++; $display("FAIL neg_onep5: got %h want %h", o, {2'b01, 64'hBFF8_0000_0000_0000, 2'b00});
        end
    endtask

    task automatic test_rounding;
        logic [67:0] o;
        xact(1'b0, 12'd2046, ONE | (106'd1 << 52) | (106'd1 << 51), 1'b0, 1'b0, o);
        n_cmp++;
        if (o !== {2'b01, TIE_EXP}) begin
            n_fail++; $display("FAIL tie_round: got %h want %h", o, {2'b01, TIE_EXP});
        end
        // Tie with even LSB stays put under either mode
        xact(1'b0, 12'd2046, ONE | (106'd1 << 51), 1'b0, 1'b0, o);
        n_cmp++;
        if (o !== {2'b01, 64'h3FF0_0000_0000_0000, 2'b00}) begin
            n_fail++; $display("FAIL tie_even: got %h want %h", o, {2'b01, 64'h3FF0_0000_0000_0000, 2'b00});
        end
        xact(1'b0, 12'd2046, ALLONES, 1'b0, 1'b0, o);
        n_cmp++;
        if (o !== {2'b01, CARRY_EXP}) begin
            n_fail++; $display("FAIL round_carry: got %h want %h", o, {2'b01, CARRY_EXP});
        end
        xact(1'b0, 12'd3069, ALLONES, 1'b0, 1'b0, o);
        n_cmp++;
        if (o !== {2'b01, CTOP_EXP}) begin
            n_fail++; $display("FAIL carry_to_ovf: got %h want %h", o, {2'b01, CTOP_EXP});
        end
    endtask

    task automatic test_range;
        logic [67:0] o;
        xact(1'b1, 12'd4094, ONE, 1'b0, 1'b0, o);
        n_cmp++;
        if (o !== {2'b01, 64'hFFF0_0000_0000_0000, 2'b10}) begin
            n_fail++; $display("FAIL overflow: got %h want %h", o, {2'b01, 64'hFFF0_0000_0000_0000, 2'b10});
        end
        xact(1'b0, 12'd1000, ONE, 1'b0, 1'b0, o);
        n_cmp++;
        if (o !== {2'b01, 64'h0, 2'b01}) begin
            n_fail++; $display("FAIL underflow: got %h want %h", o, {2'b01, 64'h0, 2'b01});
        end
        xact(1'b0, 12'd3069, ONE, 1'b0, 1'b0, o);
        n_cmp++;
        if (o !== {2'b01, 64'h7FE0_0000_0000_0000, 2'b00}) begin
            n_fail++; $display("FAIL exp_2046: got %h want %h", o, {2'b01, 64'h7FE0_0000_0000_0000, 2'b00});
        end
        xact(1'b0, 12'd3070, ONE, 1'b0, 1'b0, o);
        n_cmp++;
        if (o !== {2'b01, 64'h7FF0_0000_0000_0000, 2'b10}) begin
            n_fail++; $display("FAIL exp_2047: got %h want %h", o, {2'b01, 64'h7FF0_0000_0000_0000, 2'b10});
        end
        xact(1'b0, 12'd1024, ONE, 1'b0, 1'b0, o);
        n_cmp++;
        if (o !== {2'b01, 64'h0010_0000_0000_0000, 2'b00}) begin
            n_fail++; $display("FAIL exp_1: got %h want %h", o, {2'b01, 64'h0010_0000_0000_0000, 2'b00});
        end
        xact(1'b1, 12'd1023, ONE, 1'b0, 1'b0, o);
        n_cmp++;
        if (o !== {2'b01, 64'h8000_0000_0000_0000, 2'b01}) begin
            n_fail++; $display("FAIL exp_0: got %h want %h", o, {2'b01, 64'h8000_0000_0000_0000, 2'b01});
        end
    endtask

    task automatic test_special;
        logic [67:0] o;
        xact(1'b1, 12'd4094, ONE, 1'b1, 1'b1, o);
        n_cmp++;
        if (o !== {2'b01, 64'h7FF8_0000_0000_0000, 2'b00}) begin
            n_fail++; $display("FAIL nan_priority: got %h want %h", o, {2'b01, 64'h7FF8_0000_0000_0000, 2'b00});
        end
        xact(1'b1, 12'd4094, ONE, 1'b1, 1'b0, o);
        n_cmp++;
        if (o !== {2'b01, 64'h8000_0000_0000_0000, 2'b00}) begin
            n_fail++; $display("FAIL zero_signed: got %h want %h", o, {2'b01, 64'h8000_0000_0000_0000, 2'b00});
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] exp_r [4];
        exp_r[0] = 64'h3FF0_0000_0000_0000;
        exp_r[1] = 64'h4000_0000_0000_0000;
        exp_r[2] = 64'h4010_0000_0000_0000;
        exp_r[3] = 64'h4020_0000_0000_0000;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (c < 4) set_in(1'b1, 1'b0, 12'(2046 + c), ONE, 1'b0, 1'b0);
            else       in_valid = 1'b0;
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_fail++; $display("FAIL b2b_in_ready c=%0d: got %b want 1", c, in_ready);
            end
            @(posedge clk); #1;
            if (c >= 1 && c <= 4) begin
                n_cmp++;
                if ({out_valid, out_result} !== {1'b1, exp_r[c-1]}) begin
                    n_fail++; $display("FAIL b2b_out c=%0d: got v=%b %h want v=1 %h",
                                       c, out_valid, out_result, exp_r[c-1]);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        logic [63:0] exp_r [4];
        logic [63:0] held;
        logic        prev_stall;
        logic        acc;
        int          sent;
        int          got;
        sent = 0; got = 0; prev_stall = 1'b0; held = '0;
        exp_r[0] = 64'h3FF0_0000_0000_0000;
        exp_r[1] = 64'h4000_0000_0000_0000;
        exp_r[2] = 64'h4010_0000_0000_0000;
        exp_r[3] = 64'h4020_0000_0000_0000;
        for (int c = 0; c < 30 && got < 4; c++) begin
            @(negedge clk);
            out_ready = (c >= 5);
            if (sent < 4) set_in(1'b1, 1'b0, 12'(2046 + sent), ONE, 1'b0, 1'b0);
            else          in_valid = 1'b0;
            #1;
            acc = in_valid && in_ready;
            if (sent == 2 && !out_ready) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_fail++; $display("FAIL bp_in_ready c=%0d: got %b want 0", c, in_ready);
                end
            end
            if (out_valid && !out_ready) begin
                if (prev_stall) begin
                    n_cmp++;
                    if (out_result !== held) begin
                        n_fail++; $display("FAIL bp_stable c=%0d: got %h want %h", c, out_result, held);
                    end
                end
                held = out_result;
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (out_result !== exp_r[got]) begin
                    n_fail++; $display("FAIL bp_order n=%0d: got %h want %h", got, out_result, exp_r[got]);
                end
                got++;
            end
            @(posedge clk);
            if (acc) sent++;
        end
        n_cmp++;
        if (got != 4 || sent != 4) begin
            n_fail++; $display("FAIL bp_count: got sent=%0d emitted=%0d want 4/4", sent, got);
        end
    endtask

    task automatic test_reset_midflight;
        int seen;
        seen = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            set_in(1'b1, 1'b0, 12'd2046, ONE, 1'b0, 1'b0);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, out_result, in_ready} !== {1'b0, 64'h0, 1'b1}) begin
            n_fail++; $display("FAIL rst_async: got v=%b r=%h rdy=%b want v=0 r=0 rdy=1",
                               out_valid, out_result, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_fail++; $display("FAIL rst_stale: got %0d outputs want 0", seen);
        end
    endtask

    initial begin
        test_reset;
        test_normal;
        test_rounding;
        test_range;
        test_special;
        test_back_to_back;
        test_backpressure;
        test_reset_midflight;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
